seq_detect_param: RTL and testbench

Parametrised serial bit-pattern detector, the successor to the fixed five-state sequence detector FSM. The pattern length is a parameter, and the pattern itself is loadable at run time. Overlapping or non-overlapping detection is selected by an input, and input bits are qualified by a valid strobe so the stream may stall. It sits on a serial data path and flags each occurrence of the programmed pattern with a Mealy-style pulse; an optional saturating match counter is compiled in by macro.

---
 rtl/seq_detect_param.sv | 122 ++++++++++++
 tb/tb_seq_detect_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param
//
// Serial bit-pattern detector with a run-time loadable pattern. Input bits
// are qualified by x_valid, so the stream may stall for any number of
// cycles. The match flag z is a Mealy output: it rises in the same cycle as
// the final bit of the pattern on x. Overlapping or non-overlapping
// detection is selected per valid bit by the overlap input.
//
// Optional feature (macro SEQDET_MATCH_CNT_EN):
//   defined   - saturating match counter built, cnt_clr input present
//   undefined - no counter flops, no cnt_clr port, match_cnt tied to 0
//
// Parameters:
//   PAT_LEN   pattern length in bits (2..32)
//   RESET_PAT pattern loaded at reset; pat[PAT_LEN-1] is the first bit received
//   CNT_W     width of the match counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   x          serial data bit
//   x_valid    x is sampled only when high
//   overlap    1 = overlapping detection, 0 = non-overlapping
//   pat_load   single-cycle strobe loading pat_in (wins over x_valid)
//   pat_in     new pattern, same bit ordering as RESET_PAT
//   cnt_clr    synchronous counter clear (only with SEQDET_MATCH_CNT_EN)
//   z          combinational match flag
//   match_cnt  saturating count of matches
module seq_detect_param #(
    parameter int                 PAT_LEN   = 5,
    parameter logic [PAT_LEN-1:0] RESET_PAT = 5'b10100,
    parameter int                 CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               x,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
`ifdef SEQDET_MATCH_CNT_EN
    input  logic               cnt_clr,
`endif
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int                FILL_W   = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] pat_q,  pat_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_LEN-1:0] cand;
    logic               match;

    // The candidate word is the stored history plus the bit on the wire now,
    // which is what makes z respond with zero register delay.
    assign cand  = {hist_q, x};
    assign match = x_valid && !pat_load && (fill_q == FILL_MAX) && (cand == pat_q);
    assign z     = match;

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (pat_load) begin
            // A load discards any bit presented alongside it.
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (x_valid) begin
            hist_d = cand[PAT_LEN-2:0];
            // Non-overlapping mode restarts the fill so the matched bits
            // cannot contribute to the next match; history itself is kept.
            if (match && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= RESET_PAT;
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear has priority; increment stops at all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed testbench for seq_detect_param (PAT_LEN = 5, CNT_W = 2).
// Counter expectations collapse to 0 when SEQDET_MATCH_CNT_EN is undefined.
module tb_seq_detect_param;

    localparam int PAT_LEN = 5;
    localparam int CNT_W   = 2;

    logic               clk;
    logic               rst_n;
    logic               x;
    logic               x_valid;
    logic               overlap;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_in;
    logic               cnt_clr;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;

    int tests_run;
    int tests_failed;

    seq_detect_param #(
        .PAT_LEN  (PAT_LEN),
        .RESET_PAT(5'b10100),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .x_valid  (x_valid),
        .overlap  (overlap),
        .pat_load (pat_load),
        .pat_in   (pat_in),
`ifdef SEQDET_MATCH_CNT_EN
        .cnt_clr  (cnt_clr),
`endif
        .z        (z),
        .match_cnt(match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ce(input int v);
`ifdef SEQDET_MATCH_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Present one cycle of input, check z before the edge, then step past the edge.
    task automatic send(input logic b, input logic v, input logic ld, input logic expz,
                        input string tag);
        x        = b;
        x_valid  = v;
        pat_load = ld;
        #2;
        chk(tag, 32'(z), 32'(expz));
        @(posedge clk);
        #1;
        x_valid  = 1'b0;
        pat_load = 1'b0;
    endtask

    // Drive n valid bits, MSB of bits first; zmask gives expected z per bit.
    task automatic stream(input logic [31:0] bits, input int n, input logic [31:0] zmask,
                          input string tag);
        for (int i = 0; i < n; i++) begin
            send(bits[n-1-i], 1'b1, 1'b0, zmask[n-1-i], $sformatf("%s_b%0d", tag, i + 1));
        end
    endtask

    task automatic load(input logic [PAT_LEN-1:0] p);
        pat_in = p;
        send(1'b1, 1'b0, 1'b1, 1'b0, "load_z");
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("cnt_clr", 32'(match_cnt), 0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n    = 1'b0;
        x        = 1'b0;
        x_valid  = 1'b0;
        overlap  = 1'b1;
        pat_load = 1'b0;
        pat_in   = '0;
        cnt_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_z", 32'(z), 0);
        chk("rst_cnt", 32'(match_cnt), 0);
        rst_n = 1'b1;

        // Reset pattern 10100
        stream(32'b10100, 5, 32'b00001, "t1");
        chk("t1_cnt", 32'(match_cnt), ce(1));

        // Pattern 10101, overlapping then non-overlapping
        load(5'b10101);
        stream(32'b1010101, 7, 32'b0000101, "t2ov");
        chk("t2ov_cnt", 32'(match_cnt), ce(3));
        overlap = 1'b0;
        load(5'b10101);
        stream(32'b1010101, 7, 32'b0000100, "t2no");
        chk("t2no_cnt_sat", 32'(match_cnt), ce(3));
        clear_cnt();

        // Valid gaps: idle cycles with x = 0 must not complete the pattern
        overlap = 1'b1;
        load(5'b10100);
        begin
            logic [4:0] seq;
            logic [4:0] zm;
            seq = 5'b10100;
            zm  = 5'b00001;
            for (int i = 0; i < 5; i++) begin
                send(seq[4-i], 1'b1, 1'b0, zm[4-i], $sformatf("t3_b%0d", i + 1));
                if (i < 4) begin
                    for (int j = 0; j < 3; j++) begin
                        send(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("t3_idle%0d_%0d", i + 1, j));
                    end
                end
            end
        end
        chk("t3_cnt", 32'(match_cnt), ce(1));

        // Reset mid-pattern
        stream(32'b1010, 4, 32'b0000, "t4pre");
        rst_n = 1'b0;
        #1;
        chk("t4_rst_cnt", 32'(match_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stream(32'b0, 1, 32'b0, "t4post");
        stream(32'b10100, 5, 32'b00001, "t4re");
        chk("t4_cnt", 32'(match_cnt), ce(1));

        // Load coinciding with the final bit of a matching stream
        stream(32'b1010, 4, 32'b0000, "t5pre");
        pat_in = 5'b11001;
        send(1'b0, 1'b1, 1'b1, 1'b0, "t5_load_bit");
        chk("t5_cnt_hold", 32'(match_cnt), ce(1));
        stream(32'b11001, 5, 32'b00001, "t5new");
        chk("t5_cnt", 32'(match_cnt), ce(2));

        // All-ones pattern, back-to-back matches, saturation at CNT_W = 2
        clear_cnt();
        load(5'b11111);
        for (int k = 1; k <= 12; k++) begin
            send(1'b1, 1'b1, 1'b0, (k >= 5), $sformatf("t6_z%0d", k));
            chk($sformatf("t6_cnt%0d", k), 32'(match_cnt), ce((k < 5) ? 0 : ((k - 4 > 3) ? 3 : k - 4)));
        end
        clear_cnt();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
